ifft_bfp_reorder: RTL
=====================

Name: ifft_bfp_reorder

Overview:
- Post-processing stage placed directly after the ifft_clac wrapper.
- Collects one N-point IFFT output frame with its block-floating-point exponent into a ping-pong buffer.
- Re-emits the frame in natural order, with exponent compensation and saturation applied to a fixed output format.
- Output uses a valid/ready handshake toward the downstream framer (cyclic prefix and windowing).

Parameters:
- N, 64: FFT points; power of two, 16 to 1024.
- LOG2N, 6: log2(N); index and address width.
- IN_W, 16: input real/imag width, two's complement.
- OUT_W, 16: output real/imag width, two's complement.
- EXP_W, 6: width of the signed block exponent.
- SHIFT_OFS, 0: constant subtracted from the derived shift (absorbs the 1/N or gain plan).
- BITREV_IN, 0: 1 means din_index is bit-reversed and the block un-reverses it.
- CP_LEN, 16: cyclic-prefix length; used only with CP_INSERT_EN.

Ports:
- ifft_clk  in  1  clock.
- ifft_rst_n  in  1  reset, synchronous, active-low.
- din_valid  in  1  input sample strobe.
- din_real  in  IN_W  real part.
- din_imag  in  IN_W  imaginary part.
- din_index  in  LOG2N  sample position within the frame.
- din_exp  in  EXP_W  signed block exponent from the core.
- dout_ready  in  1  downstream accepts the sample.
- dout_valid  out  1  output sample valid.
- dout_real  out  OUT_W  compensated real part.
- dout_imag  out  OUT_W  compensated imaginary part.
- dout_index  out  LOG2N  natural-order index of the output sample.
- dout_sop  out  1  first sample of the output frame.
- dout_eop  out  1  last sample of the output frame.
- overflow  out  1  one-cycle pulse: input sample dropped.
- sat_flag  out  1  sticky: saturation occurred in the current output frame.

Behaviour:
- Reset (ifft_rst_n low at a clock edge):
  - dout_valid, dout_sop, dout_eop, overflow, sat_flag = 0.
  - dout_real, dout_imag, dout_index = 0.
  - Both banks empty; write count = 0; write bank = 0.
  - Reset mid-frame discards all partial and stored data; there is no output after reset until a new full frame has been written.
- Write side:
  - Every din_valid cycle writes to RAM[wbank][addr].
  - addr = BITREV_IN ? bitrev(din_index) : din_index.
  - din_exp is latched on the write-count-0 sample.
  - Frame completion is decided by the write counter reaching N, not by din_index.
  - On the Nth write: the bank is marked full with its exponent, wbank toggles and the count clears.
- Overflow:
  - If din_valid arrives while the target bank is still full (not yet drained), the sample is dropped.
  - overflow pulses 1 cycle and the counter does not advance.
- Read-side states:
  - IDLE: go to READ when any bank is full. Bank order is FIFO.
  - READ: the address counter steps 0..N-1, advancing only when the output register is empty or dout_ready is 1.
  - After the last address is issued, release the bank. Go to READ again if the other bank is full, otherwise go to IDLE. There is no bubble between back-to-back frames.
- Pipeline:
  - RAM read takes 1 cycle, then the shift/saturate output register.
  - First dout_valid appears 2 cycles after the edge that wrote the Nth sample, when the bank was already free downstream.
  - While dout_valid=1 and dout_ready=0, all outputs hold stable.
  - The pipeline must sustain 1 sample per cycle when dout_ready=1.
- Arithmetic:
  - s = -exp - SHIFT_OFS, computed at EXP_W+2 bits.
  - s>0: left shift by s.
  - s<0: arithmetic right shift by -s, rounding half toward +inf (add 2^(-s-1) before the shift).
  - s=0: pass through.
  - The result is sign-extended or truncated to OUT_W with symmetric saturation: +2^(OUT_W-1)-1 and -2^(OUT_W-1)+1.
  - Any clip sets sat_flag. sat_flag clears on the next dout_sop.
- Frame markers:
  - dout_sop accompanies index 0 of the frame.
  - dout_eop accompanies the final sample.
- Simultaneous events:
  - A write completing bank X in the same cycle that the read releases bank Y is legal; both updates take effect.
  - A write to a bank being released in that same cycle is accepted and does not count as overflow.

Optional Feature:
- Macro IFFT_BFP_CP_INSERT_EN.
- Defined:
  - Each frame is emitted as N+CP_LEN samples: addresses N-CP_LEN..N-1, then 0..N-1.
  - dout_sop is on the first CP sample; dout_index gives the RAM address.
  - The bank is released after the final sample.
  - Maximum sustained input duty becomes N/(N+CP_LEN); excess input raises overflow.
- Undefined:
  - Exactly N samples per frame; CP_LEN is ignored.

Test Plan:
- Reset, then 64 samples with re=k, im=-k, index=k, exp=0 -> 64 outputs with dout_real=k and index=k; sop at k=0, eop at k=63; first valid 2 cycles after the last write.
- BITREV_IN=1, din_index=bitrev(k), data=k -> output is natural order 0..63 with data equal to the index.
- exp=-2, input re=0x1000 -> output 0x4000. Input re=0x3000 -> output saturates to 0x7FFF, sat_flag=1, and sat_flag clears at the next sop.
- exp=+3, re=5 -> output 1 (5/8 rounded). re=-5 -> output -1.
- Two back-to-back frames, then a third while dout_ready=0 is held -> frames 1 and 2 are buffered; the first sample of frame 3 pulses overflow; outputs hold stable under the stall; the release drains frames in order.
- With IFFT_BFP_CP_INSERT_EN and CP_LEN=16 -> 80 outputs with indices 48..63 then 0..63; sop on index 48 and eop on 63 (second pass).

Source files
------------

// File: rtl/ifft_bfp_reorder.sv
// Ping-pong frame buffer after the IFFT core: re-emits each frame in natural order with
// block-exponent compensation and symmetric saturation. IFFT_BFP_CP_INSERT_EN prepends a cyclic prefix.
module ifft_bfp_reorder #(
   parameter int N         = 64,
   parameter int LOG2N     = 6,
   parameter int IN_W      = 16,
   parameter int OUT_W     = 16,
   parameter int EXP_W     = 6,
   parameter int SHIFT_OFS = 0,
   parameter int BITREV_IN = 0,
   parameter int CP_LEN    = 16
) (
   input  logic             ifft_clk,
   input  logic             ifft_rst_n,
   input  logic             din_valid,
   input  logic [IN_W-1:0]  din_real,
   input  logic [IN_W-1:0]  din_imag,
   input  logic [LOG2N-1:0] din_index,
   input  logic [EXP_W-1:0] din_exp,
   input  logic             dout_ready,
   output logic             dout_valid,
   output logic [OUT_W-1:0] dout_real,
   output logic [OUT_W-1:0] dout_imag,
   output logic [LOG2N-1:0] dout_index,
   output logic             dout_sop,
   output logic             dout_eop,
   output logic             overflow,
   output logic             sat_flag
);
`ifdef IFFT_BFP_CP_INSERT_EN
   localparam int CP_N = CP_LEN;
`else
   localparam int CP_N = 0 * CP_LEN;
`endif
   localparam int FRAME_LEN = N + CP_N;
   localparam int CNT_W     = LOG2N + 1;
   localparam int S_W       = EXP_W + 2;
   localparam int WW        = IN_W + OUT_W + 2;
   localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(FRAME_LEN - 1);
   localparam logic signed [WW-1:0] MAXV = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [WW-1:0] MINV = -MAXV;

   typedef enum logic {IDLE, READ} state_t;

   logic [2*IN_W-1:0] mem [0:2*N-1];
   logic              wbank, rbank;
   logic [LOG2N-1:0]  wcnt;
   logic [1:0]        full, full_n;
   logic [EXP_W-1:0]  bexp [2];
   logic [EXP_W-1:0]  exp_lat;
   logic [LOG2N-1:0]  waddr;
   logic              blocked, wr_ok, wr_last;
   state_t            state, state_n;
   logic [CNT_W-1:0]  rcnt, rcnt_n;
   logic              adv, issue, rel;
   logic [LOG2N-1:0]  raddr;
   logic [2*IN_W-1:0] rdata;
   logic              p1_valid, p1_sop, p1_eop;
   logic [LOG2N-1:0]  p1_index;
   logic [EXP_W-1:0]  p1_exp;
   logic signed [S_W-1:0] e_ext, shift;
   logic [OUT_W:0]    res_re, res_im;

   // Returns {clip, value}; shift amounts are clamped where the result no longer changes.
   function automatic logic [OUT_W:0] compensate(input logic signed [IN_W-1:0] x,
                                                 input logic signed [S_W-1:0]  s);
      logic signed [WW-1:0] xw, r, rnd;
      logic [S_W-1:0]       mag;
      xw  = WW'(x);
      mag = s[S_W-1] ? S_W'(-s) : S_W'(s);
      r   = xw;
      if (!s[S_W-1] && (s != '0)) begin
         if (mag > S_W'(OUT_W)) mag = S_W'(OUT_W);
         r = xw <<< mag;
      end else if (s[S_W-1]) begin
         if (mag > S_W'(IN_W + 1)) mag = S_W'(IN_W + 1);
         rnd = WW'(1) <<< (mag - 1'b1);
         r   = (xw + rnd) >>> mag;
      end
      if (r > MAXV) return {1'b1, MAXV[OUT_W-1:0]};
      if (r < MINV) return {1'b1, MINV[OUT_W-1:0]};
      return {1'b0, r[OUT_W-1:0]};
   endfunction

   assign adv = !dout_valid || dout_ready;

   always_comb begin
      waddr = din_index;
      if (BITREV_IN != 0)
         for (int unsigned i = 0; i < LOG2N; i++) waddr[i] = din_index[LOG2N-1-i];
      // A bank released by the reader this cycle is already free for the writer.
      blocked = full[wbank] && !(rel && (rbank == wbank));
      wr_ok   = din_valid && !blocked;
      wr_last = wr_ok && (wcnt == LOG2N'(N - 1));
      full_n  = full;
      if (rel)     full_n[rbank] = 1'b0;
      if (wr_last) full_n[wbank] = 1'b1;
   end

   always_ff @(posedge ifft_clk) begin
      if (!ifft_rst_n) begin
         wbank    <= 1'b0;
         rbank    <= 1'b0;
         wcnt     <= '0;
         exp_lat  <= '0;
         full     <= '0;
         bexp[0]  <= '0;
         bexp[1]  <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= din_valid && blocked;
         if (wr_ok) begin
            if (wcnt == '0) exp_lat <= din_exp;
            if (wr_last) begin
               wcnt        <= '0;
               wbank       <= ~wbank;
               bexp[wbank] <= exp_lat;
            end else begin
               wcnt <= wcnt + 1'b1;
            end
         end
         if (rel) rbank <= ~rbank;
         full <= full_n;
      end
   end

   always_ff @(posedge ifft_clk) begin
      if (wr_ok) mem[{wbank, waddr}] <= {din_real, din_imag};
      if (adv)   rdata <= mem[{rbank, raddr}];
   end

   always_ff @(posedge ifft_clk) begin
      if (!ifft_rst_n) begin
         state <= IDLE;
         rcnt  <= '0;
      end else begin
         state <= state_n;
         rcnt  <= rcnt_n;
      end
   end

   // IDLE issues position 0 itself so a newly filled bank starts without an extra cycle.
   always_comb begin
      state_n = state;
      rcnt_n  = rcnt;
      issue   = 1'b0;
      rel     = 1'b0;
      case (state)
         IDLE: if (adv && full[rbank]) begin
            issue   = 1'b1;
            rcnt_n  = CNT_W'(1);
            state_n = READ;
         end
         READ: if (adv) begin
            issue = 1'b1;
            if (rcnt == LAST_POS) begin
               rel     = 1'b1;
               rcnt_n  = '0;
               state_n = full[rbank ^ 1'b1] ? READ : IDLE;
            end else begin
               rcnt_n = rcnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
`ifdef IFFT_BFP_CP_INSERT_EN
      raddr = (rcnt < CNT_W'(CP_N)) ? LOG2N'(rcnt + CNT_W'(N - CP_N)) : LOG2N'(rcnt - CNT_W'(CP_N));
`else
      raddr = rcnt[LOG2N-1:0];
`endif
   end

   always_comb begin
      e_ext  = {{2{p1_exp[EXP_W-1]}}, p1_exp};
      shift  = -e_ext - S_W'(SHIFT_OFS);
      res_re = compensate(rdata[2*IN_W-1:IN_W], shift);
      res_im = compensate(rdata[IN_W-1:0], shift);
   end

   always_ff @(posedge ifft_clk) begin
      if (!ifft_rst_n) begin
         p1_valid   <= 1'b0;
         p1_sop     <= 1'b0;
         p1_eop     <= 1'b0;
         p1_index   <= '0;
         p1_exp     <= '0;
         dout_valid <= 1'b0;
         dout_sop   <= 1'b0;
         dout_eop   <= 1'b0;
         dout_real  <= '0;
         dout_imag  <= '0;
         dout_index <= '0;
         sat_flag   <= 1'b0;
      end else if (adv) begin
         p1_valid   <= issue;
         p1_sop     <= issue && (rcnt == '0);
         p1_eop     <= issue && (rcnt == LAST_POS);
         p1_index   <= raddr;
         p1_exp     <= bexp[rbank];
         dout_valid <= p1_valid;
         dout_sop   <= p1_valid && p1_sop;
         dout_eop   <= p1_valid && p1_eop;
         if (p1_valid) begin
            dout_real  <= res_re[OUT_W-1:0];
            dout_imag  <= res_im[OUT_W-1:0];
            dout_index <= p1_index;
            sat_flag   <= (p1_sop ? 1'b0 : sat_flag) | res_re[OUT_W] | res_im[OUT_W];
         end
      end
   end
endmodule
